// File: rtl/fwd_pkg.sv
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared select encodings and pipeline-stage entry type for the
//            forwarding / load-use hazard controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Destination field is sized for the widest supported register file.
    // Narrower REG_AW values are zero-extended into it.
    localparam int FWD_DST_W = 8;

    localparam logic [FWD_DST_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [FWD_DST_W-1:0] dst;
        logic                 we;
        logic                 is_load;
    } stage_entry_t;

    function automatic logic entry_hit(input stage_entry_t e,
                                       input logic [FWD_DST_W-1:0] src);
        return e.valid & e.we & (e.dst != REG_ZERO) & (e.dst == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_port_sel.sv
// ============================================================================
// Module   : fwd_port_sel
// Purpose  : Bypass select for one ID source port, youngest stage first.
//            FWD_WB_BYPASS_EN enables matching against the WB entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic              src_used_i,
    input  logic              id_valid_i,
    input  stage_entry_t      ex_i,
    input  stage_entry_t      mem_i,
    input  stage_entry_t      wb_i,
    output logic [1:0]        sel_o,
    output logic              ex_load_hit_o
);

    logic [FWD_DST_W-1:0] w_src;
    logic                 w_active;
    logic                 w_ex_hit;
    logic                 w_mem_hit;
    logic                 w_wb_hit;
    logic                 w_unused_bits;

    assign w_src     = FWD_DST_W'(src_addr_i);
    assign w_active  = src_used_i & id_valid_i;
    assign w_ex_hit  = w_active & entry_hit(ex_i, w_src);
    assign w_mem_hit = w_active & entry_hit(mem_i, w_src);

`ifdef FWD_WB_BYPASS_EN
    assign w_wb_hit      = w_active & entry_hit(wb_i, w_src);
    assign w_unused_bits = mem_i.is_load ^ wb_i.is_load;
`else
    // Register file writes in the first half-cycle, so WB data is already visible.
    assign w_wb_hit      = 1'b0;
    assign w_unused_bits = ^{mem_i.is_load, wb_i};
`endif

    always_comb begin
        sel_o = FWD_RF;
        if (w_ex_hit) begin
            sel_o = FWD_EX;
        end else if (w_mem_hit) begin
            sel_o = FWD_MEM;
        end else if (w_wb_hit) begin
            sel_o = FWD_WB;
        end
    end

    assign ex_load_hit_o = w_ex_hit & ex_i.is_load;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctl.sv
// ============================================================================
// Module   : fwd_hazard_ctl
// Purpose  : EX/MEM/WB destination tracking, per-port bypass selects,
//            load-use stall and saturating stall counter.
//            FWD_WB_BYPASS_EN enables WB-stage bypass (sel=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_hazard_ctl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_dst_we,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    stage_entry_t     ex_q;
    stage_entry_t     mem_q;
    stage_entry_t     wb_q;
    stage_entry_t     ex_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [NUM_SRC-1:0] w_load_hit;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
            fwd_port_sel #(
                .REG_AW (REG_AW)
            ) u_sel (
                .src_addr_i    (id_src_addr[i*REG_AW +: REG_AW]),
                .src_used_i    (id_src_used[i]),
                .id_valid_i    (id_valid),
                .ex_i          (ex_q),
                .mem_i         (mem_q),
                .wb_i          (wb_q),
                .sel_o         (fwd_sel[2*i +: 2]),
                .ex_load_hit_o (w_load_hit[i])
            );
        end
    endgenerate

    // A flush squashes the dependent instruction, so it never needs to wait.
    assign stall = (|w_load_hit) & ~flush;

    always_comb begin
        ex_d.valid   = id_valid & ~stall & ~flush;
        ex_d.dst     = FWD_DST_W'(id_dst_addr);
        ex_d.we      = id_dst_we;
        ex_d.is_load = id_is_load;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctl.sv
// ============================================================================
// Module   : tb_fwd_hazard_ctl
// Purpose  : Scoreboard bench for fwd_hazard_ctl with an independent
//            pipeline model. Honours FWD_WB_BYPASS_EN like the design.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fwd_hazard_ctl;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int CW = 4;
`ifdef FWD_WB_BYPASS_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [NS*AW-1:0] id_src_addr = '0;
    logic [NS-1:0]   id_src_used = '0;
    logic [AW-1:0]   id_dst_addr = '0;
    logic            id_dst_we = 1'b0;
    logic            id_is_load = 1'b0;
    logic            flush = 1'b0;
    logic [2*NS-1:0] fwd_sel;
    logic            stall;
    logic [CW-1:0]   stall_cnt;

    fwd_hazard_ctl #(
        .NUM_SRC (NS),
        .REG_AW  (AW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_dst_we   (id_dst_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       we;
        bit       ld;
    } ent_t;

    typedef struct {
        bit [1:0] sel [NS];
        bit       stall;
        int       cnt;
    } exp_t;

    ent_t m [3];
    int   m_cnt;
    exp_t sb [$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 3; j++) m[j] = '{0, 0, 0, 0};
        m_cnt = 0;
    endtask

    // One clock: drive ID, predict, compare mid-cycle, then advance the model.
    task automatic cycle(input string tag, input bit v, input bit [4:0] s0, input bit [4:0] s1,
                         input bit [1:0] used, input bit [4:0] d, input bit we,
                         input bit ld, input bit fl);
        exp_t e;
        exp_t o;
        bit   ld_hit;
        bit [4:0] src;
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_dst_addr = d;
        id_dst_we   = we;
        id_is_load  = ld;
        flush       = fl;
        ld_hit = 0;
        for (int p = 0; p < NS; p++) begin
            src = (p == 0) ? s0 : s1;
            e.sel[p] = 2'd0;
            for (int j = 2; j >= 0; j--) begin
                if (v && used[p] && m[j].v && m[j].we && m[j].d != 0 && m[j].d == src
                    && (j < 2 || WB_EN)) begin
                    e.sel[p] = 2'(j + 1);
                    if (j == 0 && m[0].ld) ld_hit = 1;
                end
            end
        end
        e.stall = ld_hit && !fl;
        e.cnt   = m_cnt;
        sb.push_back(e);

        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            o = sb.pop_front();
            check({tag, "_stall"}, 32'(stall), 32'(o.stall));
            check({tag, "_cnt"}, 32'(stall_cnt), 32'(o.cnt));
            if (!o.stall) begin
                check({tag, "_sel0"}, 32'(fwd_sel[1:0]), 32'(o.sel[0]));
                check({tag, "_sel1"}, 32'(fwd_sel[3:2]), 32'(o.sel[1]));
            end
        end

        m[2] = m[1];
        m[1] = m[0];
        m[0] = '{v && !e.stall && !fl, d, we, ld};
        if (e.stall && m_cnt != (1 << CW) - 1) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_sel", 32'(fwd_sel), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // EX-only hit on a non-load
        cycle("ex_prod", 1, 0, 0, 2'b00, 5, 1, 0, 0);
        cycle("ex_hit",  1, 5, 0, 2'b01, 1, 0, 0, 0);

        // EX and MEM both hold r5: youngest wins on port 1
        cycle("mm_prod1", 1, 0, 0, 2'b00, 5, 1, 0, 0);
        cycle("mm_prod2", 1, 0, 0, 2'b00, 5, 1, 0, 0);
        cycle("mm_hit",   1, 0, 5, 2'b10, 2, 0, 0, 0);

        // Load-use: one stall, then MEM forward
        cycle("lu_load",  1, 0, 0, 2'b00, 7, 1, 1, 0);
        cycle("lu_stall", 1, 7, 0, 2'b01, 3, 1, 0, 0);
        cycle("lu_after", 1, 7, 0, 2'b01, 3, 1, 0, 0);

        // Load-use with flush: no stall, EX becomes a bubble
        cycle("fl_load",  1, 0, 0, 2'b00, 7, 1, 1, 0);
        cycle("fl_flush", 1, 7, 0, 2'b01, 3, 1, 0, 1);
        cycle("fl_after", 1, 7, 7, 2'b11, 4, 1, 0, 0);

        // Register zero never forwards
        cycle("z_prod", 1, 0, 0, 2'b00, 0, 1, 0, 0);
        cycle("z_use",  1, 0, 0, 2'b11, 6, 0, 0, 0);

        // WB-only hit on r9
        cycle("wb_prod", 1, 0, 0, 2'b00, 9, 1, 0, 0);
        cycle("wb_gap1", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        cycle("wb_gap2", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        cycle("wb_use",  1, 9, 9, 2'b11, 8, 0, 0, 0);

        // Drain: three idle cycles leave nothing to forward
        repeat (3) cycle("drain", 0, 0, 0, 2'b00, 0, 0, 0, 0);
        cycle("drained", 1, 9, 5, 2'b11, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stall
        cycle("ar_load", 1, 0, 0, 2'b00, 7, 1, 1, 0);
        id_valid    = 1'b1;
        id_src_addr = {5'd0, 5'd7};
        id_src_used = 2'b01;
        id_is_load  = 1'b0;
        #2;
        check("ar_pre_stall", 32'(stall), 1);
        rst = 1'b1;
        #1;
        check("ar_stall", 32'(stall), 0);
        check("ar_sel", 32'(fwd_sel), 0);
        check("ar_cnt", 32'(stall_cnt), 0);
        id_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Self-dependent load stalls every other cycle; run past counter wrap
        repeat (2 * ((1 << CW) + 2) + 2) cycle("sat", 1, 7, 0, 2'b01, 7, 1, 1, 0);
        check("sat_final", 32'(stall_cnt), (1 << CW) - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
